ifid_stage_buf: RTL and testbench

Parametrised IF/ID pipeline stage that sits between the fetch unit and the decode/control unit. It adds a valid/ready handshake toward fetch, a one-entry skid buffer, bubble and flush insertion, and a saturating bubble counter for performance analysis. It decodes the fixed 16-bit instruction fields for the decode stage. The stall behaviour is uniform: all fields, including register specifiers, are held together.

---
 rtl/ifid_stage_buf.sv | 116 +++++++++++
 tb/tb_ifid_stage_buf.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ifid_stage_buf.sv
// rtl/ifid_stage_buf.sv - IF/ID stage: fetch handshake, one-entry skid buffer, bubble/flush insertion, field decode
module ifid_stage_buf #(
  parameter int          PC_W  = 16,
  parameter logic [15:0] NOP   = 16'hF000,
  parameter int          CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      instruction,
  input  logic [PC_W-1:0]  pc_in,
  input  logic             stall,
  input  logic             flush,
  output logic             out_valid,
  output logic [3:0]       opcode,
  output logic [2:0]       branch_cond,
  output logic [3:0]       reg_rs,
  output logic [3:0]       reg_rt,
  output logic [3:0]       reg_rd,
  output logic [3:0]       arith_imm,
  output logic [7:0]       load_save_imm,
  output logic [11:0]      call_target,
  output logic [PC_W-1:0]  pc_out,
  output logic [CNT_W-1:0] bubble_cnt
);

  logic [15:0]      m_inst_q, m_inst_d;
  logic [PC_W-1:0]  m_pc_q, m_pc_d;
  logic             m_valid_q, m_valid_d;
  logic [15:0]      s_inst_q, s_inst_d;
  logic [PC_W-1:0]  s_pc_q, s_pc_d;
  logic             s_valid_q, s_valid_d;
  logic [CNT_W-1:0] bubble_cnt_q, bubble_cnt_d;
  logic             accept;
  logic             bubble;

  assign in_ready = !s_valid_q && !flush;
  assign accept   = in_valid && in_ready;

  // Priority: flush > stall > advance; the skid entry always drains before new input.
  always_comb begin
    m_inst_d  = m_inst_q;
    m_pc_d    = m_pc_q;
    m_valid_d = m_valid_q;
    s_inst_d  = s_inst_q;
    s_pc_d    = s_pc_q;
    s_valid_d = s_valid_q;
    bubble    = 1'b0;
    if (flush) begin
      m_inst_d  = NOP;
      m_valid_d = 1'b0;
      s_valid_d = 1'b0;
      bubble    = 1'b1;
    end else if (stall) begin
      if (accept) begin
        s_inst_d  = instruction;
        s_pc_d    = pc_in;
        s_valid_d = 1'b1;
      end
    end else if (s_valid_q) begin
      m_inst_d  = s_inst_q;
      m_pc_d    = s_pc_q;
      m_valid_d = 1'b1;
      s_valid_d = 1'b0;
    end else if (accept) begin
      m_inst_d  = instruction;
      m_pc_d    = pc_in;
      m_valid_d = 1'b1;
    end else begin
      m_inst_d  = NOP;
      m_valid_d = 1'b0;
      bubble    = 1'b1;
    end
  end

  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (bubble && (bubble_cnt_q != {CNT_W{1'b1}})) begin
      bubble_cnt_d = bubble_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_inst_q     <= NOP;
      m_pc_q       <= '0;
      m_valid_q    <= 1'b0;
      s_inst_q     <= '0;
      s_pc_q       <= '0;
      s_valid_q    <= 1'b0;
      bubble_cnt_q <= '0;
    end else begin
      m_inst_q     <= m_inst_d;
      m_pc_q       <= m_pc_d;
      m_valid_q    <= m_valid_d;
      s_inst_q     <= s_inst_d;
      s_pc_q       <= s_pc_d;
      s_valid_q    <= s_valid_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign out_valid     = m_valid_q;
  assign opcode        = m_inst_q[15:12];
  assign branch_cond   = m_inst_q[10:8];
  assign reg_rs        = m_inst_q[7:4];
  assign reg_rt        = m_inst_q[3:0];
  assign reg_rd        = m_inst_q[11:8];
  assign arith_imm     = m_inst_q[3:0];
  assign load_save_imm = m_inst_q[7:0];
  assign call_target   = m_inst_q[11:0];
  assign pc_out        = m_pc_q;
  assign bubble_cnt    = bubble_cnt_q;

endmodule

// File: tb/tb_ifid_stage_buf.sv
// tb/tb_ifid_stage_buf.sv - scoreboard bench for ifid_stage_buf with a narrow-counter saturation instance
module tb_ifid_stage_buf;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] instruction = '0;
  logic [15:0] pc_in = '0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic [3:0]  opcode, reg_rs, reg_rt, reg_rd, arith_imm;
  logic [2:0]  branch_cond;
  logic [7:0]  load_save_imm;
  logic [11:0] call_target;
  logic [15:0] pc_out;
  logic [15:0] bubble_cnt;

  logic        s_rst_n = 1'b0;
  logic        s_in_ready, s_out_valid;
  logic [3:0]  s_opcode, s_reg_rs, s_reg_rt, s_reg_rd, s_arith_imm;
  logic [2:0]  s_branch_cond;
  logic [7:0]  s_load_save_imm;
  logic [11:0] s_call_target;
  logic [15:0] s_pc_out;
  logic [2:0]  s_bubble_cnt;

  always #5 clk = ~clk;

  ifid_stage_buf dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .instruction(instruction), .pc_in(pc_in), .stall(stall), .flush(flush),
    .out_valid(out_valid), .opcode(opcode), .branch_cond(branch_cond),
    .reg_rs(reg_rs), .reg_rt(reg_rt), .reg_rd(reg_rd), .arith_imm(arith_imm),
    .load_save_imm(load_save_imm), .call_target(call_target),
    .pc_out(pc_out), .bubble_cnt(bubble_cnt)
  );

  ifid_stage_buf #(.CNT_W(3)) dut_sat (
    .clk(clk), .rst_n(s_rst_n), .in_valid(1'b0), .in_ready(s_in_ready),
    .instruction(16'h0000), .pc_in(16'h0000), .stall(1'b0), .flush(1'b0),
    .out_valid(s_out_valid), .opcode(s_opcode), .branch_cond(s_branch_cond),
    .reg_rs(s_reg_rs), .reg_rt(s_reg_rt), .reg_rd(s_reg_rd), .arith_imm(s_arith_imm),
    .load_save_imm(s_load_save_imm), .call_target(s_call_target),
    .pc_out(s_pc_out), .bubble_cnt(s_bubble_cnt)
  );

  typedef struct {
    logic [15:0] pc;
    logic [3:0]  op, bc, rs, rt, rd, ai;
    logic [7:0]  ls;
    logic [11:0] ct;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic push_exp(input logic [15:0] pc, input logic [3:0] op, input logic [3:0] bc,
                          input logic [3:0] rs, input logic [3:0] rt, input logic [3:0] rd,
                          input logic [3:0] ai, input logic [7:0] ls, input logic [11:0] ct);
    exp_t e;
    e.pc = pc; e.op = op; e.bc = bc; e.rs = rs; e.rt = rt;
    e.rd = rd; e.ai = ai; e.ls = ls; e.ct = ct;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h required %0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic v, input logic [15:0] inst, input logic [15:0] pc);
    in_valid = v;
    instruction = inst;
    pc_in = pc;
  endtask

  // Monitor: an edge that is neither reset, flush nor stall loads M; a valid result must match the queue head.
  initial begin
    logic  ld;
    exp_t  e;
    logic [79:0] act, req;
    forever begin
      @(posedge clk);
      ld = rst_n && !flush && !stall;
      @(negedge clk);
      if (ld && out_valid) begin
        n_vec++;
        act = {pc_out, opcode, 1'b0, branch_cond, reg_rs, reg_rt, reg_rd, arith_imm, load_save_imm, call_target, 16'h0};
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL unexpected_output: got %h required nothing", act);
        end else begin
          e = exp_q.pop_front();
          req = {e.pc, e.op, e.bc, e.rs, e.rt, e.rd, e.ai, e.ls, e.ct, 16'h0};
          if (act !== req) begin
            n_err++;
            $display("FAIL decoded_output: got %h required %h", act, req);
          end
        end
      end
    end
  end

  initial begin
    offer(1'b1, 16'h1234, 16'h0055);
    tick();
    tick();
    chk("rst_opcode", 32'(opcode), 32'hF);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_pc_out", 32'(pc_out), 32'h0);
    chk("rst_bubble_cnt", 32'(bubble_cnt), 32'h0);
    chk("rst_in_ready", 32'(in_ready), 32'h1);
    chk("rst_call_target", 32'(call_target), 32'h000);

    rst_n = 1'b1;
    s_rst_n = 1'b1;
    offer(1'b0, 16'h0000, 16'h0000);
    tick(); tick(); tick();
    chk("idle_bubble_cnt", 32'(bubble_cnt), 32'd3);
    chk("sat_cnt_3", 32'(s_bubble_cnt), 32'd3);

    offer(1'b1, 16'h2A5C, 16'h0010);
    push_exp(16'h0010, 4'h2, 4'h2, 4'h5, 4'hC, 4'hA, 4'hC, 8'h5C, 12'hA5C);
    tick();
    offer(1'b1, 16'h7123, 16'h0011);
    push_exp(16'h0011, 4'h7, 4'h1, 4'h2, 4'h3, 4'h1, 4'h3, 8'h23, 12'h123);
    tick();
    offer(1'b1, 16'h2A5C, 16'h0012);
    push_exp(16'h0012, 4'h2, 4'h2, 4'h5, 4'hC, 4'hA, 4'hC, 8'h5C, 12'hA5C);
    tick();

    stall = 1'b1;
    offer(1'b1, 16'h3456, 16'h0020);
    #1 chk("skid_first_ready", 32'(in_ready), 32'h1);
    push_exp(16'h0020, 4'h3, 4'h4, 4'h5, 4'h6, 4'h4, 4'h6, 8'h56, 12'h456);
    tick();
    offer(1'b1, 16'h4567, 16'h0021);
    #1 chk("skid_full_ready", 32'(in_ready), 32'h0);
    tick();
    chk("stall_hold_opcode", 32'(opcode), 32'h2);
    chk("stall_hold_pc", 32'(pc_out), 32'h12);
    tick();
    chk("stall_in_ready", 32'(in_ready), 32'h0);
    chk("stall_hold_ls_imm", 32'(load_save_imm), 32'h5C);
    stall = 1'b0;
    #1 chk("release_ready", 32'(in_ready), 32'h0);
    tick();
    chk("after_release_ready", 32'(in_ready), 32'h1);
    chk("sat_cnt_max", 32'(s_bubble_cnt), 32'd7);
    push_exp(16'h0021, 4'h4, 4'h5, 4'h6, 4'h7, 4'h5, 4'h7, 8'h67, 12'h567);
    tick();
    chk("stream_bubble_cnt", 32'(bubble_cnt), 32'd3);

    stall = 1'b1;
    offer(1'b1, 16'h5678, 16'h0030);
    tick();
    offer(1'b0, 16'h0000, 16'h0000);
    flush = 1'b1;
    #1 chk("flush_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("flush_out_valid", 32'(out_valid), 32'h0);
    chk("flush_opcode", 32'(opcode), 32'hF);
    chk("flush_pc_hold", 32'(pc_out), 32'h21);
    chk("flush_bubble_cnt", 32'(bubble_cnt), 32'd4);
    flush = 1'b0;
    stall = 1'b0;
    #1 chk("post_flush_ready", 32'(in_ready), 32'h1);
    offer(1'b1, 16'h6789, 16'h0040);
    push_exp(16'h0040, 4'h6, 4'h7, 4'h8, 4'h9, 4'h7, 4'h9, 8'h89, 12'h789);
    tick();

    offer(1'b1, 16'h789A, 16'h0050);
    stall = 1'b1;
    flush = 1'b1;
    #1 chk("fsv_in_ready", 32'(in_ready), 32'h0);
    tick();
    chk("fsv_out_valid", 32'(out_valid), 32'h0);
    chk("fsv_bubble_cnt", 32'(bubble_cnt), 32'd5);
    offer(1'b0, 16'h0000, 16'h0000);
    stall = 1'b0;
    flush = 1'b0;
    tick();
    chk("fsv_no_stale", 32'(out_valid), 32'h0);
    chk("fsv_bubble_cnt2", 32'(bubble_cnt), 32'd6);
    chk("sat_cnt_stays", 32'(s_bubble_cnt), 32'd7);

    stall = 1'b1;
    offer(1'b1, 16'hABCD, 16'h0060);
    tick();
    offer(1'b0, 16'h0000, 16'h0000);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", 32'(out_valid), 32'h0);
    chk("async_rst_opcode", 32'(opcode), 32'hF);
    chk("async_rst_bubble_cnt", 32'(bubble_cnt), 32'h0);
    chk("async_rst_in_ready", 32'(in_ready), 32'h1);
    tick();
    tick();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

endmodule
